// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_alu_ctrl_adder.sv
// 4-bit ripple adder with carry-in; exposes the carry into bit 3 so the
// caller can form two's-complement overflow on the final nibble.
module nibble_adder_cin
  import nibble_serial_alu_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = a ^ b ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 4-bit adder, one nibble
// per clock, LSB first, with the carry held in a flop between cycles.
//
// state | meaning
// IDLE  | waiting for start; result/co/overflow hold last operation
// RUN   | one nibble per clock through the shared adder
// DONE  | one-cycle completion pulse, start ignored
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        co,
  output logic                        overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]          state;
  logic [IDX_W-1:0]    index;
  logic                carry;
  logic                sub_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum;
  logic                cout;
  logic                c3;

  // Subtraction is a + ~b + 1: b is inverted here, the +1 is the initial carry.
  assign a_nib = a_q[index*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[index*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

  nibble_adder_cin u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum),
    .cout (cout),
    .c3   (c3)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      index    <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      co       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            carry <= sub;
            index <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[index*NIBBLE_W +: NIBBLE_W] <= sum;
          carry <= cout;
          index <= index + 1'b1;
          if (index == LAST_IDX) begin
            co       <= cout;
            overflow <= c3 ^ cout;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
Sequencer that performs multi-precision add/subtract on wide operands. It reuses a single 4-bit carry-chain adder one nibble per clock, LSB nibble first, and propagates the carry between cycles. It sits between a requester (start/done handshake) and the shared 4-bit adder datapath. This lets the ALU handle 8/16/32-bit operations without replicating adders.

Parameters:
NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 2..8

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
result  output  W  sum/difference; held until next accepted start
co  output  1  carry out of the MSB nibble (for sub: 1 = no borrow)
overflow  output  1  two's-complement overflow of the W-bit operation

Behaviour:
Reset
- Asynchronous, active-high. Forces state = IDLE.
- Clears busy, done, result, co, overflow, the nibble index and the carry register.
- Reset mid-operation aborts the operation. No done pulse follows.

States: IDLE, RUN, DONE
- IDLE:
  - On an edge with start=1, latch a, b and sub.
  - Set carry = sub and index = 0, then go to RUN.
  - result, co and overflow keep their previous values until the RUN writes.
- RUN, each edge:
  - Nibble k = index.
  - {c_out, s} = a[k] + (b[k] XOR {4{sub}}) + carry.
  - Write s into result[4k+3:4k]. Set carry = c_out. Increment index.
  - When index = NIBBLES-1:
    - co = c_out.
    - overflow = (carry into bit 3 of that nibble) XOR c_out.
    - Go to DONE.
- DONE:
  - done = 1 for exactly this one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE.

Latency
- If start is accepted at edge E0, done is high in the cycle following edge E(NIBBLES).
- One new operation may be accepted every NIBBLES+2 cycles.

Rules
- start asserted while busy=1 is ignored. No queuing; the requester must re-assert.
- a, b and sub may change freely after acceptance, because the block uses only the latched copies.
- Arithmetic is modulo 2^W. co and overflow reflect only the final nibble.
- busy and done are registered (Moore) outputs with no combinational path from start.
- result is partially updated during RUN. It is valid only when done=1 and in the IDLE cycles after it.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIBBLE_W=4 constant.
- Natural sub-module: nibble_adder_cin.
  - A 4-bit ripple adder with carry-in.
  - Exposes sum[3:0], cout, and c3 (the carry into bit 3) for overflow detection.
  - Instantiated once and driven from the muxed nibble slices.
- The controller holds the FSM, the index counter, operand latches and the carry flop.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FFF -> result=0x2233, co=0, overflow=0; done high exactly 4 cycles after the start edge, then busy=0 the next cycle.
- add 0x7FFF+0x0001 -> result=0x8000, co=0, overflow=1; add 0xFFFF+0x0001 -> result=0x0000, co=1, overflow=0.
- sub 0x0005-0x0007 -> result=0xFFFE, co=0, overflow=0; sub 0x8000-0x0001 -> result=0x7FFF, co=1, overflow=1.
- start pulsed in RUN with a=0x1111, b=0x1111 while computing 0x0001+0x0001 -> only result=0x0002 is produced, with a single done pulse; the second request is not executed.
- Change a/b on the cycle after acceptance (0x00FF+0x0001, then a=0xAAAA) -> result=0x0100, proving operands are latched.
- Assert reset during the 2nd RUN cycle -> all outputs 0 immediately (asynchronous), no done; a subsequent 0x0003+0x0004 yields 0x0007 normally.
